// File: rtl/xosera_bus_host.sv
// Host-side initiator for the Xosera 8-bit register bus.
// Splits 16-bit register accesses into timed byte cycles; syncs the IRQ.
module xosera_bus_host #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wr_i,
  input  logic        req_lo_only_i,
  input  logic [3:0]  req_reg_i,
  input  logic [15:0] req_data_i,
  output logic        resp_valid_o,
  output logic [15:0] resp_data_o,
  output logic        bus_cs_n_o,
  output logic        bus_rd_nwr_o,
  output logic [3:0]  bus_reg_num_o,
  output logic        bus_bytesel_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_data_oe_o,
  input  logic [7:0]  bus_data_i,
  input  logic        bus_intr_i,
  output logic        intr_o
);

  if (SETUP_CYC < 1 || SETUP_CYC > 15 ||
      STROBE_CYC < 1 || STROBE_CYC > 15 ||
      HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_param
    $error("xosera_bus_host: phase lengths must be 1..15");
  end

  localparam logic [3:0] SETUP_N  = 4'(SETUP_CYC);
  localparam logic [3:0] STROBE_N = 4'(STROBE_CYC);
  localparam logic [3:0] HOLD_N   = 4'(HOLD_CYC);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, DONE
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        wr_q;
  logic        lo_q;
  logic [15:0] data_q;
  logic [7:0]  rd_hi;
  logic [7:0]  rd_lo;
  logic [2:0]  sync;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      wr_q          <= 1'b0;
      lo_q          <= 1'b0;
      data_q        <= 16'h0;
      rd_hi         <= 8'h0;
      rd_lo         <= 8'h0;
      req_ready_o   <= 1'b0;
      resp_valid_o  <= 1'b0;
      resp_data_o   <= 16'h0;
      bus_cs_n_o    <= 1'b1;
      bus_rd_nwr_o  <= 1'b1;
      bus_reg_num_o <= 4'h0;
      bus_bytesel_o <= 1'b0;
      bus_data_o    <= 8'h0;
      bus_data_oe_o <= 1'b0;
    end else begin
      resp_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          req_ready_o <= 1'b1;
          if (req_valid_i && req_ready_o) begin
            req_ready_o   <= 1'b0;
            wr_q          <= req_wr_i;
            lo_q          <= req_lo_only_i;
            data_q        <= req_data_i;
            bus_reg_num_o <= req_reg_i;
            bus_rd_nwr_o  <= ~req_wr_i;
            bus_bytesel_o <= req_lo_only_i;
            bus_data_o    <= req_lo_only_i ? req_data_i[7:0]
                                           : req_data_i[15:8];
            bus_data_oe_o <= req_wr_i;
            cnt           <= SETUP_N;
            state         <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == 4'd1) begin
            bus_cs_n_o <= 1'b0;
            cnt        <= STROBE_N;
            state      <= STROBE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        STROBE: begin
          if (cnt == 4'd1) begin
            // Read byte is latched on the last low cycle of cs_n
            if (!wr_q) begin
              if (bus_bytesel_o) rd_lo <= bus_data_i;
              else               rd_hi <= bus_data_i;
            end
            bus_cs_n_o <= 1'b1;
            cnt        <= HOLD_N;
            state      <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (cnt != 4'd1) begin
            cnt <= cnt - 4'd1;
          end else if (!bus_bytesel_o) begin
            bus_bytesel_o <= 1'b1;
            bus_data_o    <= data_q[7:0];
            cnt           <= SETUP_N;
            state         <= SETUP;
          end else begin
            bus_data_oe_o <= 1'b0;
            resp_valid_o  <= 1'b1;
            resp_data_o   <= wr_q ? 16'h0
                           : {lo_q ? 8'h00 : rd_hi, rd_lo};
            state         <= DONE;
          end
        end
        DONE: begin
          req_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two sync flops, a third for edge detect, registered pulse
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      sync   <= 3'b000;
      intr_o <= 1'b0;
    end else begin
      sync   <= {sync[1:0], bus_intr_i};
      intr_o <= sync[1] & ~sync[2];
    end
  end

endmodule

// File: tb/tb_xosera_bus_host.sv
// Randomized bench for xosera_bus_host: two parameter sets,
// cycle-by-cycle bus timeline from a phase-arithmetic model.
module tb_xosera_bus_host;

  logic clk = 1'b0;
  logic rst;
  logic bus_intr;

  logic        req_valid [2];
  logic        req_wr [2];
  logic        req_lo [2];
  logic [3:0]  req_reg [2];
  logic [15:0] req_data [2];
  logic        req_ready [2];
  logic        resp_valid [2];
  logic [15:0] resp_data [2];
  logic        cs_n [2];
  logic        rd_nwr [2];
  logic [3:0]  reg_num [2];
  logic        bsel [2];
  logic [7:0]  bdo [2];
  logic        oe [2];
  logic [7:0]  bdi [2];
  logic        intr [2];

  logic [15:0] xreg [16];

  int sc [2] = '{1, 3};
  int tc [2] = '{2, 4};
  int hc [2] = '{1, 2};

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign bdi[g] = bsel[g] ? xreg[reg_num[g]][7:0]
                            : xreg[reg_num[g]][15:8];
    xosera_bus_host #(
      .SETUP_CYC (g == 0 ? 1 : 3),
      .STROBE_CYC(g == 0 ? 2 : 4),
      .HOLD_CYC  (g == 0 ? 1 : 2)
    ) u_dut (
      .clk          (clk),
      .reset_i      (rst),
      .req_valid_i  (req_valid[g]),
      .req_ready_o  (req_ready[g]),
      .req_wr_i     (req_wr[g]),
      .req_lo_only_i(req_lo[g]),
      .req_reg_i    (req_reg[g]),
      .req_data_i   (req_data[g]),
      .resp_valid_o (resp_valid[g]),
      .resp_data_o  (resp_data[g]),
      .bus_cs_n_o   (cs_n[g]),
      .bus_rd_nwr_o (rd_nwr[g]),
      .bus_reg_num_o(reg_num[g]),
      .bus_bytesel_o(bsel[g]),
      .bus_data_o   (bdo[g]),
      .bus_data_oe_o(oe[g]),
      .bus_data_i   (bdi[g]),
      .bus_intr_i   (bus_intr),
      .intr_o       (intr[g])
    );
  end

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  // Caller sits at posedge+1; returns at posedge+1 after acceptance.
  task automatic issue(input int i, input bit wr, input bit lo,
                       input logic [3:0] r, input logic [15:0] d);
    int n = 0;
    while (req_ready[i] !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", 16'(req_ready[i]), 16'h1);
    req_valid[i] = 1'b1;
    req_wr[i]    = wr;
    req_lo[i]    = lo;
    req_reg[i]   = r;
    req_data[i]  = d;
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic follow(input int i, input bit wr, input bit lo,
                        input logic [3:0] r, input logic [15:0] d);
    int p  = sc[i] + tc[i] + hc[i];
    int nb = lo ? 1 : 2;
    logic [15:0] er;
    bit eb;
    bit ecs;
    er = wr ? 16'h0 : (lo ? {8'h00, xreg[r][7:0]} : xreg[r]);
    for (int k = 1; k <= nb * p + 1; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      if (k <= nb * p) begin
        eb  = lo ? 1'b1 : 1'((k - 1) / p);
        ecs = !(((k - 1) % p) >= sc[i] &&
                ((k - 1) % p) < sc[i] + tc[i]);
        chk("cs_n", 16'(cs_n[i]), 16'(ecs));
        chk("bytesel", 16'(bsel[i]), 16'(eb));
        chk("reg_num", 16'(reg_num[i]), 16'(r));
        chk("rd_nwr", 16'(rd_nwr[i]), 16'(!wr));
        chk("oe", 16'(oe[i]), 16'(wr));
        chk("busy_resp", 16'(resp_valid[i]), 16'h0);
        chk("busy_ready", 16'(req_ready[i]), 16'h0);
        if (wr)
          chk("wdata", 16'(bdo[i]),
              16'(eb ? d[7:0] : d[15:8]));
      end else begin
        chk("done_resp", 16'(resp_valid[i]), 16'h1);
        chk("done_cs", 16'(cs_n[i]), 16'h1);
        chk("done_oe", 16'(oe[i]), 16'h0);
        chk("resp_data", resp_data[i], er);
      end
    end
    @(posedge clk); #1;
    chk("resp_pulse", 16'(resp_valid[i]), 16'h0);
    chk("ready_next", 16'(req_ready[i]), 16'h1);
    chk("resp_hold", resp_data[i], er);
  endtask

  task automatic xfer(input int i, input bit wr, input bit lo,
                      input logic [3:0] r, input logic [15:0] d);
    issue(i, wr, lo, r, d);
    follow(i, wr, lo, r, d);
  endtask

  function automatic bit pat(input int t);
    return (t >= 2 && t < 22) || (t >= 25 && t < 45);
  endfunction

  task automatic reset_checks(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_cs"}, 16'(cs_n[i]), 16'h1);
      chk({tag, "_rdnwr"}, 16'(rd_nwr[i]), 16'h1);
      chk({tag, "_oe"}, 16'(oe[i]), 16'h0);
      chk({tag, "_reg"}, 16'(reg_num[i]), 16'h0);
      chk({tag, "_bsel"}, 16'(bsel[i]), 16'h0);
      chk({tag, "_data"}, 16'(bdo[i]), 16'h0);
      chk({tag, "_ready"}, 16'(req_ready[i]), 16'h0);
      chk({tag, "_resp"}, 16'(resp_valid[i]), 16'h0);
      chk({tag, "_rdata"}, resp_data[i], 16'h0);
      chk({tag, "_intr"}, 16'(intr[i]), 16'h0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: timeout got running expected finished");
    $fatal(1);
  end

  initial begin
    int pulses;
    rst = 1'b1;
    bus_intr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_wr[i]    = 1'b0;
      req_lo[i]    = 1'b0;
      req_reg[i]   = 4'h0;
      req_data[i]  = 16'h0;
    end
    for (int j = 0; j < 16; j++) xreg[j] = 16'($urandom);
    xreg[5] = 16'h1234;
    xreg[2] = 16'h9A7C;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    xfer(0, 1, 0, 4'd3, 16'hBEEF);
    xfer(0, 0, 0, 4'd5, 16'h0);
    xfer(0, 0, 0, 4'd5, 16'hFFFF);
    xfer(0, 1, 1, 4'd2, 16'h00A5);
    xfer(0, 0, 1, 4'd2, 16'h0);
    xfer(1, 0, 0, 4'd5, 16'h0);
    xfer(1, 1, 0, 4'd9, 16'hC3A1);

    for (int n = 0; n < 40; n++)
      xfer(int'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           4'($urandom), 16'($urandom));

    // Abort during the strobe of the second byte
    issue(0, 1, 0, 4'd7, 16'h5AC3);
    repeat (sc[0] + tc[0] + hc[0] + sc[0]) @(posedge clk);
    #1;
    chk("pre_abort_cs", 16'(cs_n[0]), 16'h0);
    rst = 1'b1;
    #1;
    reset_checks("abort");
    repeat (2) @(posedge clk);
    #1;
    chk("abort_resp", 16'(resp_valid[0]), 16'h0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("post_rst_resp", 16'(resp_valid[0]), 16'h0);
      chk("post_rst_ready", 16'(req_ready[0]), 16'h1);
    end
    xfer(0, 1, 0, 4'd1, 16'h4D2E);

    pulses = 0;
    for (int t = 0; t < 55; t++) begin
      for (int i = 0; i < 2; i++)
        chk("intr", 16'(intr[i]),
            16'(t >= 4 && pat(t - 3) && !pat(t - 4)));
      if (intr[0] === 1'b1) pulses++;
      bus_intr = pat(t);
      @(posedge clk); #1;
    end
    chk("intr_count", 16'(pulses), 16'd2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
